// File: rtl/moore_pkg.sv
`default_nettype none
// ============================================================================
// Module  : moore_pkg
// Purpose : Shared definitions for the serial bit-pattern detector: state
//           encoding width, state enumeration and the default pattern.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package moore_pkg;

  // Wide enough for PAT_LEN = 8, which needs 9 states (S0..S7 plus DETECT).
  localparam int STATE_W = 4;

  localparam int           DEF_PAT_LEN = 4;
  localparam logic [7:0]   DEF_PATTERN = 8'b0000_1011;
  localparam int           DEF_DETECT  = DEF_PAT_LEN;

  // Sk = "k leading pattern bits matched". DETECT is the index PAT_LEN,
  // so with a shorter pattern the higher codes are simply never reached.
  typedef enum logic [STATE_W-1:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8
  } state_e;

endpackage : moore_pkg
`default_nettype wire

// File: rtl/moore_if.sv
`default_nettype none
// ============================================================================
// Module  : moore_if
// Purpose : Serial-stream bundle between a bit source and the detector.
// Signals : din              - serial data bit
//           valid            - qualifies din
//           pattern_detector - high while the detector is in DETECT
// Revision: 1.0 - initial release
// ============================================================================
interface moore_if;
  logic din;
  logic valid;
  logic pattern_detector;

  modport master (output din, output valid, input  pattern_detector);
  modport slave  (input  din, input  valid, output pattern_detector);
endinterface : moore_if
`default_nettype wire

// File: rtl/moore_next_state.sv
`default_nettype none
// ============================================================================
// Module  : moore_next_state
// Purpose : Purely combinational next-state lookup (state, din) -> state.
//           The table is built at elaboration from PATTERN using the
//           longest-prefix-that-is-a-suffix rule.
// Ports   : i_state - current state
//           i_din   - incoming bit
//           o_next  - next state if the bit is accepted
// Revision: 1.0 - initial release
// ============================================================================
module moore_next_state
  import moore_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
  parameter bit                 OVERLAP = 1'b1
) (
  input  state_e i_state,
  input  logic   i_din,
  output state_e o_next
);

  localparam logic [7:0] c_pat = 8'(PATTERN);

  // Matched prefix of length k followed by bit b: return the length of the
  // longest pattern prefix that is a suffix of that string. Prefix bit j
  // (j = 0 is first received) is pat[len-1-j].
  function automatic int f_next(input logic [7:0] pat, input int len,
                                input int k, input logic b);
    logic [8:0] s;
    logic       ok;
    int         best;
    s = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < k)       s[i] = pat[len-1-i];
      else if (i == k) s[i] = b;
    end
    best = 0;
    for (int l = 1; l <= len; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++)
          if (s[k+1-l+j] != pat[len-1-j]) ok = 1'b0;
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  state_e w_tab [0:PAT_LEN][0:1];

  for (genvar g_st = 0; g_st <= PAT_LEN; g_st++) begin : g_state
    for (genvar g_b = 0; g_b < 2; g_b++) begin : g_bit
      // Without overlap, DETECT restarts from an empty prefix.
      localparam int c_k = (g_st == PAT_LEN && !OVERLAP) ? 0 : g_st;
      localparam int c_n = f_next(c_pat, PAT_LEN, c_k, g_b[0]);
      assign w_tab[g_st][g_b] = state_e'(c_n);
    end
  end

  always_comb begin
    o_next = S0;
    for (int st = 0; st <= PAT_LEN; st++)
      if (i_state == state_e'(st))
        o_next = i_din ? w_tab[st][1] : w_tab[st][0];
  end

endmodule : moore_next_state
`default_nettype wire

// File: rtl/moore.sv
`default_nettype none
// ============================================================================
// Module  : moore
// Purpose : Moore serial bit-pattern detector. One bit is accepted per clock
//           while valid is high; pattern_detector is decoded from the state
//           register only (no combinational path from din).
// Ports   : clk - clock, rising edge
//           rst - synchronous active-high reset
//           bus - moore_if.slave (din, valid in; pattern_detector out)
// Revision: 1.0 - initial release
// ============================================================================
module moore
  import moore_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
  parameter bit                 OVERLAP = 1'b1
) (
  input  wire    clk,
  input  wire    rst,
  moore_if.slave bus
);

  localparam state_e c_detect = state_e'(PAT_LEN);

  state_e r_state;
  state_e w_lut;
  state_e w_state_nxt;

  moore_next_state #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_next (
    .i_state (r_state),
    .i_din   (bus.din),
    .o_next  (w_lut)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S0;
    else     r_state <= w_state_nxt;
  end

  // din is only looked at when valid is high, so X/Z on an idle cycle
  // cannot reach the state register.
  always_comb begin
    w_state_nxt          = r_state;
    bus.pattern_detector = (r_state == c_detect);
    if (bus.valid) w_state_nxt = w_lut;
  end

endmodule : moore
`default_nettype wire

// File: tb/tb_moore.sv
`default_nettype none
// ============================================================================
// Module  : tb_moore
// Purpose : Self-checking bench for moore. Two instances (overlap / no
//           overlap) see the same stream; a shift-register model predicts
//           the output of every cycle into a scoreboard queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_moore;
  import moore_pkg::*;

  localparam int         c_len = 4;
  localparam logic [3:0] c_pat = 4'b1011;

  typedef struct packed { logic ov; logic nov; } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  moore_if bus_ov ();
  moore_if bus_nov ();

  moore #(.PAT_LEN(c_len), .PATTERN(c_pat), .OVERLAP(1'b1)) u_ov (
    .clk (clk), .rst (rst), .bus (bus_ov.slave));
  moore #(.PAT_LEN(c_len), .PATTERN(c_pat), .OVERLAP(1'b0)) u_nov (
    .clk (clk), .rst (rst), .bus (bus_nov.slave));

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_exp[$];

  // Behavioural model state.
  logic [3:0] m_sr_ov, m_sr_nov;
  int         m_cnt_ov, m_cnt_nov;
  exp_t       m_exp = '0;
  int         m_rise_ov, m_rise_nov;

  // Observed pulse statistics.
  int   cyc = 0;
  int   rise_ov, rise_nov, last_ov, gap_ov;
  logic prev_ov = 1'b0, prev_nov = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_tests++;
      if (bus_ov.pattern_detector !== e.ov) begin
        n_fail++;
        $display("FAIL sb_overlap cyc=%0d got=%b exp=%b", cyc, bus_ov.pattern_detector, e.ov);
      end
      n_tests++;
      if (bus_nov.pattern_detector !== e.nov) begin
        n_fail++;
        $display("FAIL sb_nonoverlap cyc=%0d got=%b exp=%b", cyc, bus_nov.pattern_detector, e.nov);
      end
    end
    if (bus_ov.pattern_detector === 1'b1 && prev_ov !== 1'b1) begin
      rise_ov++;
      if (last_ov >= 0) gap_ov = cyc - last_ov;
      last_ov = cyc;
    end
    if (bus_nov.pattern_detector === 1'b1 && prev_nov !== 1'b1) rise_nov++;
    prev_ov  = bus_ov.pattern_detector;
    prev_nov = bus_nov.pattern_detector;
  end

  task automatic clear_stats();
    rise_ov = 0; rise_nov = 0; last_ov = -1; gap_ov = 0;
    m_rise_ov = 0; m_rise_nov = 0;
  endtask

  // Drive one clock of stimulus, update the model, push the expectation.
  task automatic step(input logic r, input logic v, input logic d);
    exp_t prev;
    rst = r;
    bus_ov.valid = v;  bus_ov.din = d;
    bus_nov.valid = v; bus_nov.din = d;
    prev = m_exp;
    if (r) begin
      m_sr_ov = '0; m_sr_nov = '0; m_cnt_ov = 0; m_cnt_nov = 0;
      m_exp = '0;
    end else if (v) begin
      m_sr_ov  = {m_sr_ov[2:0], d};
      m_cnt_ov++;
      m_exp.ov = (m_cnt_ov >= c_len) && (m_sr_ov == c_pat);
      m_sr_nov = {m_sr_nov[2:0], d};
      m_cnt_nov++;
      m_exp.nov = (m_cnt_nov >= c_len) && (m_sr_nov == c_pat);
      if (m_exp.nov) m_cnt_nov = 0;
    end
    if (m_exp.ov && !prev.ov)   m_rise_ov++;
    if (m_exp.nov && !prev.nov) m_rise_nov++;
    q_exp.push_back(m_exp);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i]);
  endtask

  task automatic test_reset();
    clear_stats();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      n_tests++;
      if (u_ov.r_state !== S0 || bus_ov.pattern_detector !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold state=%0d out=%b exp state=0 out=0", u_ov.r_state, bus_ov.pattern_detector);
      end
    end
    send(16'b1011, 4);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 1) begin
      n_fail++;
      $display("FAIL reset_first_match pulses=%0d exp=1", rise_ov);
    end
  endtask

  task automatic test_overlap();
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    send(16'b1011011, 7);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 2 || gap_ov !== 3) begin
      n_fail++;
      $display("FAIL overlap_pulses pulses=%0d gap=%0d exp pulses=2 gap=3", rise_ov, gap_ov);
    end
    n_tests++;
    if (rise_nov !== 1) begin
      n_fail++;
      $display("FAIL nonoverlap_1011011 pulses=%0d exp=1", rise_nov);
    end
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    send(16'b10111011, 8);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_nov !== 2) begin
      n_fail++;
      $display("FAIL nonoverlap_10111011 pulses=%0d exp=2", rise_nov);
    end
  endtask

  task automatic test_valid_gaps();
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    send(16'b10, 2);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'bx);
    step(1'b0, 1'b0, 1'b1);
    send(16'b11, 2);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 1 || rise_nov !== 1) begin
      n_fail++;
      $display("FAIL valid_gaps pulses ov=%0d nov=%0d exp 1 1", rise_ov, rise_nov);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    send(16'b101, 3);
    step(1'b1, 1'b1, 1'b1);
    send(16'b1, 1);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_discard pulses=%0d exp=0", rise_ov);
    end
    send(16'b1011, 4);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 1) begin
      n_fail++;
      $display("FAIL mid_reset_recover pulses=%0d exp=1", rise_ov);
    end
  endtask

  task automatic test_near_miss();
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    send(16'b101011, 6);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 1) begin
      n_fail++;
      $display("FAIL near_miss_101011 pulses=%0d exp=1", rise_ov);
    end
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    send(16'b1111, 4);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== 0 || rise_nov !== 0) begin
      n_fail++;
      $display("FAIL near_miss_1111 pulses ov=%0d nov=%0d exp 0 0", rise_ov, rise_nov);
    end
  endtask

  task automatic test_random();
    int seed;
    logic b;
    seed = 32'h1234_5678;
    step(1'b1, 1'b0, 1'b0);
    clear_stats();
    for (int i = 0; i < 150; i++) begin
      b = $random(seed);
      step(1'b0, 1'b1, b);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (rise_ov !== m_rise_ov) begin
      n_fail++;
      $display("FAIL random_overlap pulses=%0d exp=%0d", rise_ov, m_rise_ov);
    end
    n_tests++;
    if (rise_nov !== m_rise_nov) begin
      n_fail++;
      $display("FAIL random_nonoverlap pulses=%0d exp=%0d", rise_nov, m_rise_nov);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_ov.valid = 1'b0;  bus_ov.din = 1'b0;
    bus_nov.valid = 1'b0; bus_nov.din = 1'b0;
    m_sr_ov = '0; m_sr_nov = '0; m_cnt_ov = 0; m_cnt_nov = 0;
    clear_stats();
    @(negedge clk);
    #1;
    test_reset();
    test_overlap();
    test_valid_gaps();
    test_mid_reset();
    test_near_miss();
    test_random();
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_moore
`default_nettype wire
